// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU datapath widths, reset vector and address type
package cpu_pkg;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] PC_RESET_VECTOR = 32'h0000_0000;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/program_counter.sv
// program_counter: enable-gated PC register with async active-low reset and optional LSB alignment
module program_counter #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = cpu_pkg::PC_RESET_VECTOR,
    parameter int ALIGN_BITS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCWre,
    input  logic [ADDR_W-1:0] newAddress,
    output logic [ADDR_W-1:0] currentAddress
);
    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return a & ({ADDR_W{1'b1}} << ALIGN_BITS);
    endfunction

    always_ff @(posedge clk or negedge rst)
        if (!rst) currentAddress <= RESET_ADDR;
        else if (PCWre) currentAddress <= align(newAddress);

    a_reset_value: assert property (@(posedge clk) !rst |-> currentAddress == RESET_ADDR);
    a_hold: assert property (@(posedge clk) disable iff (!rst) !PCWre |=> $stable(currentAddress));
    a_load: assert property (@(posedge clk) disable iff (!rst) PCWre |=> currentAddress == align($past(newAddress)));
    a_pcwre_known: assert property (@(posedge clk) rst |-> !$isunknown(PCWre));
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed vectors for program_counter, default and word-aligned builds
module tb_program_counter;
    logic        clk = 0;
    logic        rst = 0;
    logic        PCWre = 0;
    logic [31:0] newAddress = '0;
    logic [31:0] currentAddress;
    logic [31:0] aligned_address;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    program_counter dut (
        .clk(clk), .rst(rst), .PCWre(PCWre),
        .newAddress(newAddress), .currentAddress(currentAddress)
    );

    program_counter #(.ALIGN_BITS(2)) dut_aligned (
        .clk(clk), .rst(rst), .PCWre(PCWre),
        .newAddress(newAddress), .currentAddress(aligned_address)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 10; i++) begin
            PCWre = i[0];
            newAddress = 32'(i * 4 + 4);
            step();
            check("reset_hold", currentAddress, 32'h0);
        end
        check("reset_hold_aligned", aligned_address, 32'h0);

        rst = 1;
        PCWre = 1;
        newAddress = 32'h4;
        step();
        check("first_load", currentAddress, 32'h4);
        newAddress = 32'h8;
        step();
        check("second_load", currentAddress, 32'h8);

        newAddress = 32'h10;
        step();
        check("load_10", currentAddress, 32'h10);
        PCWre = 0;
        for (int i = 0; i < 3; i++) begin
            newAddress = 32'h14 + 32'(i * 4);
            step();
            check("hold", currentAddress, 32'h10);
        end
        PCWre = 1;
        step();
        check("load_after_hold", currentAddress, 32'h1C);

        newAddress = 32'h0040_0020;
        step();
        check("load_midrun", currentAddress, 32'h0040_0020);
        #3 rst = 0;
        #1 check("async_reset", currentAddress, 32'h0);
        newAddress = 32'hDEAD_BEEF;
        step();
        check("reset_over_load", currentAddress, 32'h0);
        check("reset_over_load_aligned", aligned_address, 32'h0);
        rst = 1;

        newAddress = 32'hFFFF_FFFF;
        step();
        check("all_ones", currentAddress, 32'hFFFF_FFFF);
        check("all_ones_aligned", aligned_address, 32'hFFFF_FFFC);
        newAddress = 32'h0000_0000;
        step();
        check("zero", currentAddress, 32'h0);
        newAddress = 32'h8000_0000;
        step();
        check("msb", currentAddress, 32'h8000_0000);
        newAddress = 32'h0000_0007;
        step();
        check("unaligned_raw", currentAddress, 32'h7);
        check("unaligned_masked", aligned_address, 32'h4);

        newAddress = 32'h20;
        step();
        check("glitch_load", currentAddress, 32'h20);
        #2 newAddress = 32'h24;
        PCWre = 0;
        step();
        check("glitch_ignored", currentAddress, 32'h20);
        #2 PCWre = 1;
        newAddress = 32'h28;
        #3 PCWre = 0;
        step();
        check("pulse_between_edges", currentAddress, 32'h20);
        check("pulse_between_edges_aligned", aligned_address, 32'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 32-bit program counter register for the single-cycle/multi-cycle MIPS CPU datapath.
- Holds the address of the current instruction and drives instruction memory and the PC+4/branch/jump adders.
- Loads the next-address value selected by the datapath mux when the control unit asserts PCWre; otherwise it holds.
- One clock. Reset is asynchronous and active-low.

Parameters:
- ADDR_W, 32, width of the address bus and the PC register.
- RESET_ADDR, 32'h0000_0000, value loaded into currentAddress while rst is low.
- ALIGN_BITS, 0, number of LSBs forced to zero on load (0 = no masking; 2 = word-align for MIPS).

Ports:
- clk  input  1  system clock; PC updates on the rising edge.
- rst  input  1  asynchronous active-low reset; rst=0 forces the PC to RESET_ADDR.
- PCWre  input  1  PC write enable from the control unit; 1 = load newAddress at the next rising edge.
- newAddress  input  ADDR_W  next PC value from the next-PC mux.
- currentAddress  output  ADDR_W  registered current PC value.

Behaviour:
- State: one ADDR_W-bit register, which directly drives currentAddress. There is no combinational path from inputs to output.
- Reset:
  - The falling edge of rst sets currentAddress = RESET_ADDR immediately, without waiting for clk.
  - While rst=0, the register holds RESET_ADDR regardless of clk, PCWre and newAddress.
  - Reset applied mid-operation overrides any pending load.
- Release from reset:
  - The first load can occur at the first rising clk edge at which rst=1 and PCWre=1.
  - The deassertion edge of rst must be synchronised externally; the block adds no synchronizer.
- Load:
  - At a rising clk edge with rst=1 and PCWre=1, currentAddress <= newAddress with the low ALIGN_BITS bits cleared.
  - Latency is one clock edge. The new value is visible after the edge and stable for the whole following cycle.
- Hold: at a rising clk edge with rst=1 and PCWre=0, currentAddress keeps its value. This covers multi-cycle stalls and halt.
- Arithmetic: none. The block does not increment; the datapath computes PC+4.
- Wrap-around: none performed; any ADDR_W value is accepted verbatim, including 32'hFFFF_FFFF.
- Simultaneous events:
  - PCWre and newAddress are sampled only at the rising edge; changes between edges have no effect.
  - If rst falls coincident with a clk edge, reset wins.
- X-handling: an X on PCWre while rst=1 is a protocol error. Behaviour is undefined, and the verification bench shall flag it with an assertion.

Decomposition:
- Shared package cpu_pkg:
  - constant ADDR_W = 32
  - constant PC_RESET_VECTOR = 32'h0000_0000
  - typedef addr_t as logic [ADDR_W-1:0]
- program_counter imports addr_t and the reset vector as parameter defaults.
- No sub-module: a single always block with async reset and an enable-gated load.
- The optional alignment mask is a local function inside the module.
- The RTL should include assertions covering: reset value, hold-when-disabled, one-edge load latency, and PCWre not X outside reset.

Test Plan:
1. Reset hold: rst=0 for 10 cycles with PCWre toggling every 2 half-periods and newAddress incrementing -> currentAddress stays 32'h0 throughout.
2. Load after release: rst 0->1, newAddress=32'h0000_0004, PCWre=1 at the next rising edge -> currentAddress=32'h4 one edge later; then newAddress=32'h8 -> 32'h8 on the following edge.
3. Hold with PCWre=0: currentAddress=32'h10, PCWre=0, newAddress changes 32'h14, 32'h18, 32'h1C over 3 edges -> currentAddress stays 32'h10; PCWre=1 -> 32'h1C on the next edge.
4. Async reset mid-run: currentAddress=32'h0040_0020, drop rst between clock edges -> currentAddress=32'h0 before the next rising edge; hold rst low across an edge with PCWre=1, newAddress=32'hDEAD_BEEF -> still 32'h0.
5. Boundary values: load 32'hFFFF_FFFF, then 32'h0000_0000, then 32'h8000_0000 with PCWre=1 -> each appears verbatim one edge later; ALIGN_BITS=2 build loads 32'h0000_0007 -> 32'h0000_0004.
6. Mid-cycle input glitch: with PCWre=1 and newAddress=32'h20 at the edge, change newAddress to 32'h24 and PCWre to 0 between edges -> currentAddress=32'h20 and unchanged at the next edge.
